conv_seq_ctrl: RTL and testbench

- Sequencer for the 3x3 line-buffer convolver.
- Accepts a start command with image dimensions, then loads 9 filter taps from a valid/ready stream and streams W*H pixels into the line buffer.
- Asserts mac_enable only on cycles whose window is fully inside the image, and tags convolver results with valid/last so downstream logic needs no position counting.
- Sits between the layer controller/memory reader and one convolver instance.

---
 rtl/conv_seq_ctrl_pkg.sv | 25 ++
 rtl/conv_seq_ctrl_if.sv | 11 +
 rtl/conv_seq_ctrl_pos_counter.sv | 55 +++++
 rtl/conv_seq_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_seq_ctrl_pkg.sv
// Shared definitions for the 3x3 convolver sequencer: FSM state encoding,
// kernel geometry and default widths.
package conv_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_FLT = 3'd1,
        ST_STREAM   = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam int FLT_TAPS    = 9;
    localparam int KERNEL      = 3;
    localparam int DATA_W_DEF  = 16;
    localparam int ACC_W_DEF   = 36;
    localparam int DIM_W_DEF   = 8;
    localparam int MAC_LAT_DEF = 3;

    // An image smaller than the kernel has no valid window at all.
    function automatic logic dims_ok(input int w, input int h);
        return (w >= KERNEL) && (h >= KERNEL);
    endfunction

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// Valid/ready stream bundle used for the filter-tap and pixel inputs.
interface conv_seq_ctrl_if #(
    parameter int DATA_W = 16
) ();
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              ready;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/conv_seq_ctrl_pos_counter.sv
// Raster position tracker (col/row with wrap at the image width) that flags
// beats whose 3x3 window lies fully inside the image, plus the final pixel.
module conv_pos_counter
    import conv_seq_ctrl_pkg::*;
#(
    parameter int DIM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    input  logic [DIM_W-1:0] img_w,
    input  logic [DIM_W-1:0] img_h,
    output logic [DIM_W-1:0] col,
    output logic [DIM_W-1:0] row,
    output logic             window_valid,
    output logic             last_pos
);

    logic [DIM_W-1:0] col_reg, col_next;
    logic [DIM_W-1:0] row_reg, row_next;

    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        if (clear) begin
            col_next = '0;
            row_next = '0;
        end else if (advance) begin
            if (col_reg == img_w - DIM_W'(1)) begin
                col_next = '0;
                row_next = row_reg + DIM_W'(1);
            end else begin
                col_next = col_reg + DIM_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_reg <= '0;
            row_reg <= '0;
        end else begin
            col_reg <= col_next;
            row_reg <= row_next;
        end
    end

    // Flags describe the current (pre-increment) position of the beat.
    assign col          = col_reg;
    assign row          = row_reg;
    assign window_valid = (row_reg >= DIM_W'(KERNEL - 1)) && (col_reg >= DIM_W'(KERNEL - 1));
    assign last_pos     = (row_reg == img_h - DIM_W'(1)) && (col_reg == img_w - DIM_W'(1));

endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequencer for one 3x3 line-buffer convolver: loads 9 taps, streams W*H pixels,
// gates mac_enable and tags results. Optional perf counters: CONV_SEQ_CTRL_PERF_EN.
module conv_seq_ctrl
    import conv_seq_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int DIM_W   = DIM_W_DEF,
    parameter int MAC_LAT = MAC_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  img_w,
    input  logic [DIM_W-1:0]  img_h,
    conv_seq_ctrl_if.slave    flt,
    conv_seq_ctrl_if.slave    pix,
    output logic              shifting_filter,
    output logic [DATA_W-1:0] input_filter,
    output logic              shifting_line,
    output logic [DATA_W-1:0] input_line,
    output logic              line_buffer_reset,
    output logic [DIM_W-1:0]  row_length,
    output logic              mac_enable,
    input  logic [ACC_W-1:0]  output_mac,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef CONV_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stalls
`endif
);

    localparam int DRN_W = $clog2(MAC_LAT + 1);
    localparam logic [3:0]       TAP_LAST   = 4'(FLT_TAPS - 1);
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(MAC_LAT - 1);

    state_t            state_reg, state_next;
    logic [DIM_W-1:0]  img_w_reg, img_h_reg, row_length_reg;
    logic [3:0]        tap_cnt_reg;
    logic [DRN_W-1:0]  drain_cnt_reg;
    logic [DATA_W-1:0] last_pix_reg;
    logic              err_reg;
    logic [MAC_LAT-1:0] vld_pipe_reg, vld_pipe_next;
    logic [MAC_LAT-1:0] last_pipe_reg, last_pipe_next;
    logic              out_valid_reg, out_last_reg;
    logic [ACC_W-1:0]  out_data_reg;

    logic flt_rdy, pix_rdy, flt_fire, pix_fire;
    logic start_ok, start_bad, in_idle;
    logic window_valid, last_pos, mac_en;
    logic [DIM_W-1:0] pos_col, pos_row;

    assign in_idle   = (state_reg == ST_IDLE);
    assign start_ok  = start && in_idle && dims_ok(int'(img_w), int'(img_h));
    assign start_bad = start && in_idle && !dims_ok(int'(img_w), int'(img_h));
    assign flt_fire  = flt.valid && flt_rdy;
    assign pix_fire  = pix.valid && pix_rdy;

    always_comb begin
        state_next = state_reg;
        flt_rdy    = 1'b0;
        pix_rdy    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_ok) state_next = ST_LOAD_FLT;
            end
            ST_LOAD_FLT: begin
                flt_rdy = 1'b1;
                if (flt.valid && tap_cnt_reg == TAP_LAST) state_next = ST_STREAM;
            end
            ST_STREAM: begin
                pix_rdy = 1'b1;
                if (pix.valid && last_pos) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_cnt_reg == DRAIN_LAST) state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            img_w_reg      <= '0;
            img_h_reg      <= '0;
            row_length_reg <= '0;
            tap_cnt_reg    <= '0;
            drain_cnt_reg  <= '0;
            last_pix_reg   <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;
            err_reg   <= start_bad;
            if (start_ok) begin
                img_w_reg      <= img_w;
                img_h_reg      <= img_h;
                row_length_reg <= img_w - DIM_W'(KERNEL);
                tap_cnt_reg    <= '0;
            end else if (flt_fire) begin
                tap_cnt_reg <= tap_cnt_reg + 4'd1;
            end
            drain_cnt_reg <= (state_reg == ST_DRAIN) ? drain_cnt_reg + DRN_W'(1) : '0;
            if (pix_fire) last_pix_reg <= pix.data;
        end
    end

    conv_pos_counter #(
        .DIM_W (DIM_W)
    ) u_pos (
        .clk          (clk),
        .rst          (rst),
        .clear        (in_idle),
        .advance      (pix_fire),
        .img_w        (img_w_reg),
        .img_h        (img_h_reg),
        .col          (pos_col),
        .row          (pos_row),
        .window_valid (window_valid),
        .last_pos     (last_pos)
    );

    assign mac_en = pix_fire && window_valid;

    // Delay line: a result leaves the convolver MAC_LAT cycles after its enable.
    for (genvar gi = 0; gi < MAC_LAT; gi++) begin : g_dly
        if (gi == 0) begin : g_head
            assign vld_pipe_next[gi]  = mac_en;
            assign last_pipe_next[gi] = mac_en && last_pos;
        end else begin : g_tail
            assign vld_pipe_next[gi]  = vld_pipe_reg[gi-1];
            assign last_pipe_next[gi] = last_pipe_reg[gi-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe_reg  <= '0;
            last_pipe_reg <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            vld_pipe_reg  <= vld_pipe_next;
            last_pipe_reg <= last_pipe_next;
            out_valid_reg <= vld_pipe_reg[MAC_LAT-1];
            out_last_reg  <= vld_pipe_reg[MAC_LAT-1] && last_pipe_reg[MAC_LAT-1];
            out_data_reg  <= vld_pipe_reg[MAC_LAT-1] ? output_mac : '0;
        end
    end

`ifdef CONV_SEQ_CTRL_PERF_EN
    logic [31:0] perf_cycles_reg, perf_stalls_reg;

    // Counters stop on their own once busy drops in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cycles_reg <= '0;
            perf_stalls_reg <= '0;
        end else if (start_ok) begin
            perf_cycles_reg <= '0;
            perf_stalls_reg <= '0;
        end else begin
            if (busy) perf_cycles_reg <= perf_cycles_reg + 32'd1;
            if (state_reg == ST_STREAM && !pix.valid) perf_stalls_reg <= perf_stalls_reg + 32'd1;
        end
    end

    assign perf_cycles = perf_cycles_reg;
    assign perf_stalls = perf_stalls_reg;
`endif

    assign flt.ready         = flt_rdy;
    assign pix.ready         = pix_rdy;
    assign shifting_filter   = flt_fire;
    assign input_filter      = flt_fire ? flt.data : '0;
    assign shifting_line     = pix_fire;
    assign input_line        = pix_fire ? pix.data : last_pix_reg;
    assign line_buffer_reset = !((state_reg == ST_STREAM) || (state_reg == ST_DRAIN));
    assign row_length        = row_length_reg;
    assign mac_enable        = mac_en;
    assign out_valid         = out_valid_reg;
    assign out_data          = out_data_reg;
    assign out_last          = out_last_reg;
    assign busy              = (state_reg == ST_LOAD_FLT) || (state_reg == ST_STREAM) ||
                               (state_reg == ST_DRAIN);
    assign done              = (state_reg == ST_DONE);
    assign err               = err_reg;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl with a behavioural 3-cycle convolver model;
// optional perf ports connected when CONV_SEQ_CTRL_PERF_EN is defined.
module tb_conv_seq_ctrl;

    localparam int DATA_W  = 16;
    localparam int ACC_W   = 36;
    localparam int DIM_W   = 8;
    localparam int MAC_LAT = 3;

    logic              clk, rst, start;
    logic [DIM_W-1:0]  img_w, img_h;
    logic              shifting_filter, shifting_line, line_buffer_reset, mac_enable;
    logic [DATA_W-1:0] input_filter, input_line;
    logic [DIM_W-1:0]  row_length;
    logic [ACC_W-1:0]  output_mac, out_data;
    logic              out_valid, out_last, busy, done, err;
`ifdef CONV_SEQ_CTRL_PERF_EN
    logic [31:0]       perf_cycles, perf_stalls;
`endif

    conv_seq_ctrl_if #(.DATA_W(DATA_W)) flt_if ();
    conv_seq_ctrl_if #(.DATA_W(DATA_W)) pix_if ();

    conv_seq_ctrl #(
        .DATA_W (DATA_W), .ACC_W (ACC_W), .DIM_W (DIM_W), .MAC_LAT (MAC_LAT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .img_w             (img_w),
        .img_h             (img_h),
        .flt               (flt_if),
        .pix               (pix_if),
        .shifting_filter   (shifting_filter),
        .input_filter      (input_filter),
        .shifting_line     (shifting_line),
        .input_line        (input_line),
        .line_buffer_reset (line_buffer_reset),
        .row_length        (row_length),
        .mac_enable        (mac_enable),
        .output_mac        (output_mac),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_last          (out_last),
        .busy              (busy),
        .done              (done),
`ifdef CONV_SEQ_CTRL_PERF_EN
        .perf_cycles       (perf_cycles),
        .perf_stalls       (perf_stalls),
`endif
        .err               (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;
    int cyc = 0;
    logic clr_req;
    int cur_w;
    logic [DATA_W-1:0] img [0:1023];
    logic [ACC_W-1:0]  exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
        end
    endtask

    // Convolver model: window sum from the accepted pixel history, MAC_LAT cycles late.
    logic [DATA_W-1:0] hist [0:1023];
    logic [DATA_W-1:0] mtap [0:8];
    int mbeat, mtap_n;
    logic [ACC_W-1:0] s_d [0:2];
    logic             s_v [0:2];

    function automatic logic [ACC_W-1:0] win_sum(input int k, input logic [DATA_W-1:0] cur, input int w);
        logic [ACC_W-1:0] acc;
        logic [DATA_W-1:0] v;
        int idx;
        acc = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                idx = k - (2 - i) * w - (2 - j);
                if (idx == k)      v = cur;
                else if (idx >= 0) v = hist[idx];
                else               v = '0;
                acc += ACC_W'(mtap[i*3+j]) * ACC_W'(v);
            end
        end
        return acc;
    endfunction

    always @(posedge clk) begin
        if (clr_req) begin
            mbeat  <= 0;
            mtap_n <= 0;
        end else begin
            if (shifting_filter && mtap_n < 9) begin
                mtap[mtap_n] <= input_filter;
                mtap_n       <= mtap_n + 1;
            end
            if (shifting_line && mbeat < 1024) begin
                hist[mbeat] <= input_line;
                mbeat       <= mbeat + 1;
            end
        end
        s_v[0] <= mac_enable;
        s_d[0] <= mac_enable ? win_sum(mbeat, input_line, cur_w) : '0;
        s_v[1] <= s_v[0];
        s_d[1] <= s_d[0];
        s_v[2] <= s_v[1];
        s_d[2] <= s_d[1];
    end

    assign output_mac = s_v[2] ? s_d[2] : 36'hBADBADBAD;

    // Monitor: records results and protocol events, sampled on the falling edge.
    logic [ACC_W-1:0] got_q[$];
    int ov_cyc[$];
    int n_out, last_idx, post_last, done_cnt, done_cyc, sl_bad;
    int sf_cnt, sf9_cyc, first_pr_cyc, last_beat_cyc, err_cnt;

    always @(negedge clk) begin
        if (clr_req) begin
            got_q.delete();
            ov_cyc.delete();
            n_out <= 0; last_idx <= 0; post_last <= 0; done_cnt <= 0; done_cyc <= 0;
            sl_bad <= 0; sf_cnt <= 0; sf9_cyc <= 0; first_pr_cyc <= -1;
            last_beat_cyc <= 0; err_cnt <= 0;
        end else begin
            if (out_valid) begin
                got_q.push_back(out_data);
                ov_cyc.push_back(cyc);
                n_out <= n_out + 1;
                if (out_last) last_idx <= n_out + 1;
                if (last_idx != 0) post_last <= post_last + 1;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (shifting_line && !(pix_if.valid && pix_if.ready)) sl_bad <= sl_bad + 1;
            if (shifting_line) last_beat_cyc <= cyc;
            if (shifting_filter) begin
                sf_cnt <= sf_cnt + 1;
                if (sf_cnt == 8) sf9_cyc <= cyc;
            end
            if (pix_if.ready && first_pr_cyc < 0) first_pr_cyc <= cyc;
            if (err) err_cnt <= err_cnt + 1;
        end
    end

    function automatic int count_mism();
        int m = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) m++;
        return m;
    endfunction

    task automatic do_run(input int w, input int h, input int mode, input int stall_mod,
                          input logic [15:0] bubble_mask, input int abort_at, input int start_mid_at);
        int k, t, n, c;
        logic [ACC_W-1:0] acc;
        cur_w = w;
        for (int r = 0; r < h; r++)
            for (int cc = 0; cc < w; cc++)
                img[r*w+cc] = (mode == 0) ? DATA_W'(r*w + cc + 1) : DATA_W'((r*13 + cc*7 + 5) % 251);
        exp_q.delete();
        for (int r = 2; r < h; r++) begin
            for (int cc = 2; cc < w; cc++) begin
                acc = '0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        acc += ACC_W'(i*3 + j + 1) * ACC_W'(img[(r-2+i)*w + cc-2+j]);
                exp_q.push_back(acc);
            end
        end
        clr_req = 1'b1;
        start   = 1'b1;
        img_w   = DIM_W'(w);
        img_h   = DIM_W'(h);
        @(posedge clk); #1;
        clr_req = 1'b0;
        start   = 1'b0;
        k = 0; t = 0;
        while (k < 9 && t < 200) begin
            flt_if.valid = (t < 16) ? !bubble_mask[t] : 1'b1;
            flt_if.data  = DATA_W'(k + 1);
            @(negedge clk);
            if (flt_if.valid && flt_if.ready) k++;
            @(posedge clk); #1;
            t++;
        end
        flt_if.valid = 1'b0;
        if (k < 9) check("flt_timeout", 64'(k), 64'd9);
        n = 0; c = 0; t = 0;
        while (n < w*h && t < 5000) begin
            if (abort_at >= 0 && n == abort_at) break;
            pix_if.valid = (stall_mod == 0) || ((c % stall_mod) != stall_mod - 1);
            pix_if.data  = img[n];
            start = (start_mid_at >= 0 && n == start_mid_at && c == start_mid_at);
            img_w = start ? DIM_W'(2) : DIM_W'(w);
            @(negedge clk);
            if (pix_if.valid && pix_if.ready) n++;
            @(posedge clk); #1;
            c++; t++;
        end
        pix_if.valid = 1'b0;
        start = 1'b0;
        img_w = DIM_W'(w);
        if (abort_at >= 0) return;
        if (n < w*h) check("pix_timeout", 64'(n), 64'(w*h));
        t = 0;
        while (done_cnt == 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == 0) check("done_timeout", 64'd0, 64'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int n1, n3, nother;
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n1, n3, nother;
        n_checks = 0; n_errors = 0;
        rst = 1'b1; start = 1'b0; img_w = '0; img_h = '0; clr_req = 1'b0; cur_w = 3;
        flt_if.valid = 1'b0; flt_if.data = '0; pix_if.valid = 1'b0; pix_if.data = '0;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_lbr", 64'(line_buffer_reset), 64'd1);
        check("rst_flt_ready", 64'(flt_if.ready), 64'd0);
        check("rst_pix_ready", 64'(pix_if.ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_row_length", 64'(row_length), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // 30x30, taps 1..9, continuous pixels
        do_run(30, 30, 1, 0, 16'h0000, -1, -1);
        check("t1_count", 64'(n_out), 64'd784);
        check("t1_data_mism", 64'(count_mism()), 64'd0);
        check("t1_last_idx", 64'(last_idx), 64'd784);
        check("t1_post_last", 64'(post_last), 64'd0);
        check("t1_done_cnt", 64'(done_cnt), 64'd1);
        check("t1_done_lat", 64'(done_cyc - last_beat_cyc), 64'(MAC_LAT + 1));
        check("t1_row_length", 64'(row_length), 64'd27);
        check("t1_sf_cnt", 64'(sf_cnt), 64'd9);
        n1 = 0; n3 = 0; nother = 0;
        for (int i = 1; i < ov_cyc.size(); i++) begin
            if (ov_cyc[i] - ov_cyc[i-1] == 1)      n1++;
            else if (ov_cyc[i] - ov_cyc[i-1] == 3) n3++;
            else                                   nother++;
        end
        check("t1_gap_runs", 64'(n1), 64'd756);
        check("t1_gap_groups", 64'(n3), 64'd27);
        check("t1_gap_other", 64'(nother), 64'd0);

        // 5x4, pixel stall every 3rd cycle, two filter bubbles
        do_run(5, 4, 0, 3, 16'b0000_0000_0010_0100, -1, -1);
        check("t2_count", 64'(n_out), 64'd6);
        check("t2_data_mism", 64'(count_mism()), 64'd0);
        if (got_q.size() == 6) begin
            check("t2_first_val", 64'(got_q[0]), 64'd411);
            check("t2_last_val", 64'(got_q[5]), 64'd726);
        end else begin
            check("t2_result_q", 64'(got_q.size()), 64'd6);
        end
        check("t2_last_idx", 64'(last_idx), 64'd6);
        check("t2_sl_bad", 64'(sl_bad), 64'd0);
        check("t4_sf_cnt", 64'(sf_cnt), 64'd9);
        check("t4_stream_after_9th", 64'(first_pr_cyc - sf9_cyc), 64'd1);

        // undersized images
        clr_req = 1'b1; start = 1'b1; img_w = 8'd2; img_h = 8'd5;
        @(posedge clk); #1;
        clr_req = 1'b0; start = 1'b0;
        check("t3_err_pulse", 64'(err), 64'd1);
        check("t3_busy", 64'(busy), 64'd0);
        check("t3_flt_ready", 64'(flt_if.ready), 64'd0);
        check("t3_pix_ready", 64'(pix_if.ready), 64'd0);
        @(posedge clk); #1;
        check("t3_err_clear", 64'(err), 64'd0);
        check("t3_busy_after", 64'(busy), 64'd0);
        start = 1'b1; img_w = 8'd5; img_h = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        check("t3_err_h", 64'(err), 64'd1);
        check("t3_flt_ready_h", 64'(flt_if.ready), 64'd0);

        // reset after pixel 100, then a clean rerun
        do_run(30, 30, 1, 0, 16'h0000, 100, -1);
        rst = 1'b0;
        #2;
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_lbr", 64'(line_buffer_reset), 64'd1);
        check("t5_mac_enable", 64'(mac_enable), 64'd0);
        check("t5_out_valid", 64'(out_valid), 64'd0);
        check("t5_out_last", 64'(out_last), 64'd0);
        check("t5_pix_ready", 64'(pix_if.ready), 64'd0);
        check("t5_row_length", 64'(row_length), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("t5_no_done", 64'(done_cnt), 64'd0);
        check("t5_no_last", 64'(last_idx), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        do_run(30, 30, 1, 0, 16'h0000, -1, -1);
        check("t5_rerun_count", 64'(n_out), 64'd784);
        check("t5_rerun_mism", 64'(count_mism()), 64'd0);
        check("t5_rerun_last", 64'(last_idx), 64'd784);

        // start pulse during STREAM is ignored
        do_run(5, 4, 0, 0, 16'h0000, -1, 7);
        check("t6_count", 64'(n_out), 64'd6);
        check("t6_data_mism", 64'(count_mism()), 64'd0);
        check("t6_no_err", 64'(err_cnt), 64'd0);
        check("t6_done_cnt", 64'(done_cnt), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
